// File: rtl/caliptra_prim_count_hardened.sv
// Hardened up/down counter: a primary up-counter paired with a complemented shadow
// down-counter. A sticky error is raised whenever the pair stops summing to all-ones.
module caliptra_prim_count_hardened #(
  parameter int unsigned      Width           = 8,
  parameter logic [Width-1:0] ResetValue      = {Width{1'b0}},
  parameter logic [3:0]       PossibleActions = 4'hF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             set_i,
  input  logic [Width-1:0] set_cnt_i,
  input  logic             incr_en_i,
  input  logic             decr_en_i,
  input  logic [Width-1:0] step_i,
  output logic [Width-1:0] cnt_o,
  output logic [Width-1:0] cnt_next_o,
  output logic             sat_o,
  output logic             zero_o,
  output logic             err_o
);

  localparam logic [Width-1:0] MaxVal    = {Width{1'b1}};
  localparam logic [Width:0]   MaxValExt = {1'b0, MaxVal};

  // Saturating add: the carry bit is kept so overflow clamps at MaxVal instead of wrapping
  function automatic logic [Width-1:0] sat_add(input logic [Width-1:0] a,
                                               input logic [Width-1:0] b);
    logic [Width:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum > MaxValExt) begin
      sat_add = MaxVal;
    end else begin
      sat_add = sum[Width-1:0];
    end
  endfunction

  function automatic logic [Width-1:0] sat_sub(input logic [Width-1:0] a,
                                               input logic [Width-1:0] b);
    if (a < b) begin
      sat_sub = {Width{1'b0}};
    end else begin
      sat_sub = a - b;
    end
  endfunction

  logic [Width-1:0] up_q, dn_q;
  logic [Width-1:0] up_d_s, dn_d_s;
  logic             err_q, sat_q, zero_q;
  logic             clr_s, set_s, incr_s, decr_s;
  logic             mismatch_s;

  assign clr_s  = clr_i     & PossibleActions[0];
  assign set_s  = set_i     & PossibleActions[1];
  assign incr_s = incr_en_i & PossibleActions[2];
  assign decr_s = decr_en_i & PossibleActions[3];

  // Next-state for both counters; the shadow is updated from its own value, never from up_d_s
  always_comb begin
    up_d_s = up_q;
    dn_d_s = dn_q;
    if (clr_s) begin
      up_d_s = ResetValue;
      dn_d_s = MaxVal - ResetValue;
    end else if (set_s) begin
      up_d_s = set_cnt_i;
      dn_d_s = MaxVal - set_cnt_i;
    end else if (incr_s && !decr_s) begin
      up_d_s = sat_add(up_q, step_i);
      dn_d_s = sat_sub(dn_q, step_i);
    end else if (decr_s && !incr_s) begin
      up_d_s = sat_sub(up_q, step_i);
      dn_d_s = sat_add(dn_q, step_i);
    end else begin
      up_d_s = up_q;
      dn_d_s = dn_q;
    end
  end

  assign mismatch_s = ({1'b0, up_q} + {1'b0, dn_q}) != MaxValExt;

  // Counter pair, status flags and sticky error; only rst_i clears the error
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      up_q   <= ResetValue;
      dn_q   <= MaxVal - ResetValue;
      err_q  <= 1'b0;
      sat_q  <= (ResetValue == MaxVal);
      zero_q <= (ResetValue == {Width{1'b0}});
    end else begin
      up_q   <= up_d_s;
      dn_q   <= dn_d_s;
      err_q  <= err_q | mismatch_s;
      sat_q  <= (up_d_s == MaxVal);
      zero_q <= (up_d_s == {Width{1'b0}});
    end
  end

  assign cnt_o      = up_q;
  assign cnt_next_o = up_d_s;
  assign sat_o      = sat_q;
  assign zero_o     = zero_q;
  assign err_o      = err_q;

endmodule

// File: tb/tb_caliptra_prim_count_hardened.sv
// Bench for caliptra_prim_count_hardened: directed steps plus random traffic on a full-action
// instance and a Clr|Incr-only instance, both compared against an integer reference model.
module tb_caliptra_prim_count_hardened;

  localparam int RST_VAL = 5;
  localparam int MAX_VAL = 255;

  logic       clk, rst;
  logic       clr_a, set_a, incr_a, decr_a;
  logic [7:0] set_cnt_a, step_a, cnt_a, cnt_next_a;
  logic       sat_a, zero_a, err_a;
  logic       clr_b, set_b, incr_b, decr_b;
  logic [7:0] set_cnt_b, step_b, cnt_b, cnt_next_b;
  logic       sat_b, zero_b, err_b;

  int checks = 0;
  int errors = 0;
  int model_a, model_b;
  logic err_exp_a, err_exp_b;

  caliptra_prim_count_hardened #(
    .Width(8), .ResetValue(8'd5), .PossibleActions(4'hF)
  ) dut_a (
    .clk_i(clk), .rst_i(rst), .clr_i(clr_a), .set_i(set_a), .set_cnt_i(set_cnt_a),
    .incr_en_i(incr_a), .decr_en_i(decr_a), .step_i(step_a), .cnt_o(cnt_a),
    .cnt_next_o(cnt_next_a), .sat_o(sat_a), .zero_o(zero_a), .err_o(err_a)
  );

  caliptra_prim_count_hardened #(
    .Width(8), .ResetValue(8'd5), .PossibleActions(4'h5)
  ) dut_b (
    .clk_i(clk), .rst_i(rst), .clr_i(clr_b), .set_i(set_b), .set_cnt_i(set_cnt_b),
    .incr_en_i(incr_b), .decr_en_i(decr_b), .step_i(step_b), .cnt_o(cnt_b),
    .cnt_next_o(cnt_next_b), .sat_o(sat_b), .zero_o(zero_b), .err_o(err_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain integer arithmetic over the action rules
  function automatic int ref_next(input int cnt, input logic clr, input logic set,
                                  input logic incr, input logic decr, input int setv,
                                  input int step, input logic [3:0] mask);
    logic c, s, i, d;
    c = clr & mask[0];
    s = set & mask[1];
    i = incr & mask[2];
    d = decr & mask[3];
    if (c) return RST_VAL;
    if (s) return setv;
    if (i && !d) return (cnt + step > MAX_VAL) ? MAX_VAL : cnt + step;
    if (d && !i) return (cnt - step < 0) ? 0 : cnt - step;
    return cnt;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    {clr_a, set_a, incr_a, decr_a} = 4'b0000;
    {clr_b, set_b, incr_b, decr_b} = 4'b0000;
    set_cnt_a = 8'd0; step_a = 8'd0;
    set_cnt_b = 8'd0; step_b = 8'd0;
  endtask

  // Called just after a negedge with inputs applied; returns at the following negedge
  task automatic run_cycle(input string tag);
    int ea, eb;
    ea = ref_next(model_a, clr_a, set_a, incr_a, decr_a, int'(set_cnt_a), int'(step_a), 4'hF);
    eb = ref_next(model_b, clr_b, set_b, incr_b, decr_b, int'(set_cnt_b), int'(step_b), 4'h5);
    #1;
    chk({tag, "_next_a"}, 32'(cnt_next_a), 32'(ea));
    chk({tag, "_next_b"}, 32'(cnt_next_b), 32'(eb));
    @(posedge clk);
    #1;
    model_a = ea;
    model_b = eb;
    chk({tag, "_cnt_a"},  32'(cnt_a),  32'(ea));
    chk({tag, "_sat_a"},  32'(sat_a),  32'(ea == MAX_VAL));
    chk({tag, "_zero_a"}, 32'(zero_a), 32'(ea == 0));
    chk({tag, "_err_a"},  32'(err_a),  32'(err_exp_a));
    chk({tag, "_cnt_b"},  32'(cnt_b),  32'(eb));
    chk({tag, "_sat_b"},  32'(sat_b),  32'(eb == MAX_VAL));
    chk({tag, "_zero_b"}, 32'(zero_b), 32'(eb == 0));
    chk({tag, "_err_b"},  32'(err_b),  32'(err_exp_b));
    @(negedge clk);
  endtask

  task automatic rand_inputs();
    clr_a  = ($urandom_range(15) == 0);
    set_a  = ($urandom_range(7) == 0);
    incr_a = ($urandom_range(1) == 1);
    decr_a = ($urandom_range(1) == 1);
    set_cnt_a = 8'($urandom_range(255));
    step_a = ($urandom_range(3) == 0) ? 8'd0 : 8'($urandom_range(255) >> $urandom_range(7));
    clr_b  = ($urandom_range(15) == 0);
    set_b  = ($urandom_range(3) == 0);
    incr_b = ($urandom_range(1) == 1);
    decr_b = ($urandom_range(1) == 1);
    set_cnt_b = 8'($urandom_range(255));
    step_b = 8'($urandom_range(255) >> $urandom_range(7));
  endtask

  task automatic async_reset_check(input string tag);
    #2;
    rst = 1'b1;
    #1;
    chk({tag, "_cnt_a"},  32'(cnt_a),  32'(RST_VAL));
    chk({tag, "_zero_a"}, 32'(zero_a), 32'd0);
    chk({tag, "_sat_a"},  32'(sat_a),  32'd0);
    chk({tag, "_err_a"},  32'(err_a),  32'd0);
    chk({tag, "_cnt_b"},  32'(cnt_b),  32'(RST_VAL));
    @(negedge clk);
    rst = 1'b0;
    model_a = RST_VAL;
    model_b = RST_VAL;
    err_exp_a = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    model_a = RST_VAL;
    model_b = RST_VAL;
    err_exp_a = 1'b0;
    err_exp_b = 1'b0;

    // Reset state
    #12;
    chk("rst_cnt_a",  32'(cnt_a),  32'd5);
    chk("rst_zero_a", 32'(zero_a), 32'd0);
    chk("rst_sat_a",  32'(sat_a),  32'd0);
    chk("rst_err_a",  32'(err_a),  32'd0);
    chk("rst_cnt_b",  32'(cnt_b),  32'd5);
    @(negedge clk);
    rst = 1'b0;

    // Load 0, then increment by 100 up to saturation
    set_a = 1'b1; set_cnt_a = 8'd0;
    run_cycle("load0");
    chk("load0_abs", 32'(cnt_a), 32'd0);
    set_a = 1'b0; incr_a = 1'b1; step_a = 8'd100;
    run_cycle("incr1");
    chk("incr1_abs", 32'(cnt_a), 32'd100);
    run_cycle("incr2");
    chk("incr2_abs", 32'(cnt_a), 32'd200);
    run_cycle("incr3");
    chk("incr3_abs", 32'(cnt_a), 32'd255);
    chk("incr3_sat", 32'(sat_a), 32'd1);
    idle_inputs();

    // Decrement by 7 from 10 down to the floor
    set_a = 1'b1; set_cnt_a = 8'd10;
    run_cycle("load10");
    set_a = 1'b0; decr_a = 1'b1; step_a = 8'd7;
    run_cycle("decr1");
    chk("decr1_abs", 32'(cnt_a), 32'd3);
    run_cycle("decr2");
    chk("decr2_zero", 32'(zero_a), 32'd1);
    run_cycle("decr3");
    chk("decr3_abs", 32'(cnt_a), 32'd0);
    idle_inputs();

    // Priority: Clr > Set > Incr, and Incr+Decr holds
    clr_a = 1'b1; set_a = 1'b1; set_cnt_a = 8'h80; incr_a = 1'b1; step_a = 8'd3;
    run_cycle("prio_clr");
    chk("prio_clr_abs", 32'(cnt_a), 32'd5);
    clr_a = 1'b0;
    run_cycle("prio_set");
    chk("prio_set_abs", 32'(cnt_a), 32'h80);
    set_a = 1'b0; decr_a = 1'b1;
    run_cycle("prio_both");
    chk("prio_both_abs", 32'(cnt_a), 32'h80);
    idle_inputs();

    // Masked Set/Decr on the Clr|Incr instance are ignored; Incr and Clr still act
    set_b = 1'b1; set_cnt_b = 8'h33; decr_b = 1'b1; step_b = 8'd2;
    run_cycle("mask_ign");
    chk("mask_ign_abs", 32'(cnt_b), 32'd5);
    set_b = 1'b0; decr_b = 1'b0; incr_b = 1'b1; step_b = 8'd3;
    run_cycle("mask_incr");
    chk("mask_incr_abs", 32'(cnt_b), 32'd8);
    incr_b = 1'b0; clr_b = 1'b1;
    run_cycle("mask_clr");
    idle_inputs();

    // Asynchronous reset mid-count at 40
    set_a = 1'b1; set_cnt_a = 8'd40;
    run_cycle("load40");
    idle_inputs();
    async_reset_check("async_rst");
    run_cycle("post_rst");

    // Random traffic
    for (int n = 0; n < 300; n++) begin
      rand_inputs();
      run_cycle("rand");
    end
    idle_inputs();

    // Fault injection on the shadow counter at 20
    set_a = 1'b1; set_cnt_a = 8'd20;
    run_cycle("load20");
    idle_inputs();
    force dut_a.dn_q = 8'd234;
    err_exp_a = 1'b1;
    run_cycle("fault");
    release dut_a.dn_q;
    run_cycle("fault_hold");
    clr_a = 1'b1;
    run_cycle("fault_clr");
    clr_a = 1'b0; set_a = 1'b1; set_cnt_a = 8'h40;
    run_cycle("fault_set");
    for (int n = 0; n < 20; n++) begin
      rand_inputs();
      run_cycle("fault_rand");
    end
    idle_inputs();
    async_reset_check("fault_rst");
    run_cycle("fault_after1");
    run_cycle("fault_after2");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
